// File: rtl/noc_load_scheduler.sv
// Schedules filter then per-timestep ifmap packets from payload memory into the mesh, then collects PE acks.
// Latency: 3 cycles from start or from a packet handshake to the next pkt_valid; done 1 cycle after the last ack.
// Backpressure: pkt_valid/pkt_data hold in SEND until pkt_ready; acks accepted only while waiting for them.
module noc_load_scheduler #(
    parameter int ROW          = 4,
    parameter int COL          = 4,
    parameter int FILTER_WIDTH = 8,
    parameter int TIMESTEPS    = 2,
    localparam int NUM_PE      = ROW * COL,
    localparam int PAY_W       = 5 * FILTER_WIDTH,
    localparam int WIDTH       = 13 + PAY_W,
    localparam int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [6:0]        timestep,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PAY_W-1:0]  mem_rdata,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [WIDTH-1:0]  pkt_data,
    input  logic              ack_valid,
    output logic              ack_ready,
    input  logic [WIDTH-1:0]  ack_data
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, WAIT_ACK, DONE} state_t;
    localparam logic FILTER = 1'b0;
    localparam logic IFMAP  = 1'b1;

    state_t            state, state_nxt;
    logic              phase;
    logic [3:0]        pe;
    logic [6:0]        seq;
    logic [NUM_PE-1:0] bitmap;

    logic              last_pe;
    logic              last_pass;
    logic [3:0]        ack_src;
    logic              ack_fire;
    logic              src_ok;
    logic [NUM_PE-1:0] ack_bit;
    logic              ack_new;
    logic [NUM_PE-1:0] bitmap_upd;
    logic              bitmap_full;
    logic              ack_payload_unused;

    assign last_pe   = (32'(pe) == NUM_PE - 1);
    assign last_pass = !(32'(timestep) < TIMESTEPS - 1);

    // An ack only counts if it names a real node that has not answered yet this pass.
    assign ack_src            = ack_data[WIDTH-1 -: 4];
    assign ack_payload_unused = ^ack_data[WIDTH-5:0];
    assign ack_fire           = ack_valid && ack_ready;
    assign src_ok             = (32'(ack_src) < NUM_PE);
    assign ack_bit            = src_ok ? (NUM_PE'(1) << ack_src) : '0;
    assign ack_new            = ack_fire && src_ok && ((bitmap & ack_bit) == '0);
    assign bitmap_upd         = ack_new ? (bitmap | ack_bit) : bitmap;
    assign bitmap_full        = &bitmap_upd;

    assign mem_addr = (phase == FILTER) ? ADDR_W'(pe)
                    : ADDR_W'(NUM_PE) + ADDR_W'(timestep) * ADDR_W'(NUM_PE) + ADDR_W'(pe);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = FETCH;
            FETCH:    state_nxt = CAPTURE;
            CAPTURE:  state_nxt = SEND;
            SEND: begin
                if (pkt_ready) state_nxt = (!last_pe || phase == FILTER) ? FETCH : WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bitmap_full) state_nxt = last_pass ? DONE : FETCH;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == FETCH) || (state == CAPTURE) || (state == SEND) || (state == WAIT_ACK);
        mem_rd_en = (state == FETCH);
        pkt_valid = (state == SEND);
        ack_ready = (state == WAIT_ACK);
        done      = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= FILTER;
            pe       <= '0;
            seq      <= '0;
            timestep <= '0;
            bitmap   <= '0;
            err      <= 1'b0;
            pkt_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        phase    <= FILTER;
                        pe       <= '0;
                        timestep <= '0;
                        bitmap   <= '0;
                    end
                end
                CAPTURE: pkt_data <= {pe, {1'b0, phase}, seq, mem_rdata};
                SEND: begin
                    if (pkt_ready) begin
                        seq <= seq + 7'd1;
                        if (!last_pe) begin
                            pe <= pe + 4'd1;
                        end else begin
                            pe <= '0;
                            if (phase == FILTER) phase <= IFMAP;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (ack_fire && !ack_new) err <= 1'b1;
                    if (bitmap_full) begin
                        bitmap <= '0;
                        if (!last_pass) begin
                            timestep <= timestep + 7'd1;
                            pe       <= '0;
                        end
                    end else begin
                        bitmap <= bitmap_upd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_load_scheduler.sv
// Directed bench for noc_load_scheduler on a 2x2 mesh with two ifmap passes.
module tb_noc_load_scheduler;
    localparam int NPE   = 4;
    localparam int PW    = 40;
    localparam int WIDTH = 13 + PW;
    localparam int AW    = 10;

    logic             clk = 1'b0;
    logic             rst, start, busy, done, err;
    logic [6:0]       timestep;
    logic             mem_rd_en;
    logic [AW-1:0]    mem_addr;
    logic [PW-1:0]    mem_rdata;
    logic             pkt_valid, pkt_ready;
    logic [WIDTH-1:0] pkt_data;
    logic             ack_valid, ack_ready;
    logic [WIDTH-1:0] ack_data;

    noc_load_scheduler #(.ROW(2), .COL(2), .FILTER_WIDTH(8), .TIMESTEPS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .timestep(timestep), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_data(ack_data)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] payload(input logic [AW-1:0] a);
        return {8'hA5, 8'h3C, 14'd0, a};
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rdata <= payload(mem_addr);

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc, first_vld_cyc, done_cyc, done_n, ack_n, last_ack_cyc;
    logic [WIDTH-1:0] pkt_log[$];
    int pkt_cyc[$];
    logic [6:0] pkt_ts[$];
    int addr_log[$];
    int ack_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        pkt_log.delete(); pkt_cyc.delete(); pkt_ts.delete(); addr_log.delete();
        first_vld_cyc = -1; done_cyc = -1; done_n = 0; ack_n = 0; last_ack_cyc = -1;
    endtask

    // One clock: present acks, log handshakes seen before the edge, sample #1 after it.
    task automatic step();
        ack_valid = (ack_q.size() > 0);
        ack_data  = '0;
        if (ack_valid) ack_data[WIDTH-1 -: 4] = 4'(ack_q[0]);
        if (!rst) begin
            if (pkt_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (pkt_valid && pkt_ready) begin
                pkt_log.push_back(pkt_data); pkt_cyc.push_back(cyc); pkt_ts.push_back(timestep);
            end
            if (mem_rd_en) addr_log.push_back(int'(mem_addr));
            if (ack_valid && ack_ready) begin
                ack_n++; last_ack_cyc = cyc; void'(ack_q.pop_front());
            end
        end
        @(posedge clk); #1;
        cyc++;
        if (done) begin done_n++; done_cyc = cyc; end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pkt_ready = 1'b1; ack_q.delete();
        step(); step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic load_acks();
        for (int p = 0; p < 2; p++) for (int n = 0; n < NPE; n++) ack_q.push_back(n);
    endtask

    task automatic wait_done(input int extra_start_at, input int budget);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            start = (n == extra_start_at);
            step();
            n++;
        end
        start = 1'b0;
        check("done_seen", done_n, 1);
        check("busy_at_done", busy, 0);
        step();
        check("done_one_cycle", done, 0);
    endtask

    task automatic run_to_done(input int extra_start_at);
        start_cyc = cyc;
        start = 1'b1; step(); start = 1'b0;
        check("busy_after_start", busy, 1);
        wait_done(extra_start_at, 300);
    endtask

    task automatic check_packets(input string tag);
        logic [WIDTH-1:0] p;
        check({tag, "_pkt_count"}, pkt_log.size(), 12);
        for (int i = 0; i < 12 && i < pkt_log.size() && i < addr_log.size(); i++) begin
            p = pkt_log[i];
            check({tag, "_addr"}, addr_log[i], i);
            check({tag, "_seq"}, p[PW+6:PW], i);
            check({tag, "_type"}, p[PW+8:PW+7], (i < 4) ? 0 : 1);
            check({tag, "_dest"}, p[WIDTH-1 -: 4], i % 4);
            check({tag, "_payload"}, p[PW-1:0], payload(AW'(i)));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] exp0;
        int n;
        rst = 1'b1; start = 1'b0; pkt_ready = 1'b1; ack_valid = 1'b0; ack_data = '0;
        clear_logs();
        exp0 = {4'd0, 2'b00, 7'd0, payload(10'd0)};

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_timestep", timestep, 0);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_ack_ready", ack_ready, 0);
        check("rst_pkt_data", pkt_data, 0);

        // Nominal run: 12 packets, two ack passes.
        load_acks();
        run_to_done(-1);
        check_packets("nom");
        check("nom_first_latency", first_vld_cyc - start_cyc, 3);
        if (pkt_cyc.size() >= 9) begin
            check("nom_cadence", pkt_cyc[1] - pkt_cyc[0], 3);
            check("nom_pass1_start", pkt_cyc[8] - start_cyc, 31);
            check("nom_pass1_timestep", pkt_ts[8], 1);
        end
        check("nom_acks", ack_n, 8);
        check("nom_done_after_ack", done_cyc - last_ack_cyc, 1);
        check("nom_run_len", done_cyc - start_cyc, 45);
        check("nom_err", err, 0);

        // Start pulsed mid-run must change nothing.
        do_reset();
        load_acks();
        run_to_done(10);
        check("busy_start_pkts", pkt_log.size(), 12);
        check("busy_start_run_len", done_cyc - start_cyc, 45);

        // Backpressure on the first packet.
        do_reset();
        load_acks();
        pkt_ready = 1'b0;
        start_cyc = cyc;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!pkt_valid && n < 10) begin step(); n++; end
        check("stall_latency", cyc - start_cyc, 3);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", pkt_valid, 1);
            check("stall_data", pkt_data, exp0);
            step();
        end
        pkt_ready = 1'b1;
        check("stall_valid_at_ready", pkt_valid, 1);
        step();
        check("stall_next_rd_en", mem_rd_en, 1);
        check("stall_next_addr", mem_addr, 1);
        wait_done(-1, 300);
        check_packets("stall");
        check("stall_run_len", done_cyc - start_cyc, 50);

        // Duplicate ack from node 2 in pass 0.
        do_reset();
        ack_q = '{0, 1, 2, 2, 3, 0, 1, 2, 3};
        run_to_done(-1);
        check("dup_err", err, 1);
        check("dup_acks", ack_n, 9);
        check("dup_pkts", pkt_log.size(), 12);
        check("dup_run_len", done_cyc - start_cyc, 46);

        // Out-of-range source node.
        do_reset();
        check("oor_err_cleared", err, 0);
        ack_q = '{7, 0, 1, 2, 3, 0, 1, 2, 3};
        run_to_done(-1);
        check("oor_err", err, 1);
        check("oor_acks", ack_n, 9);
        check("oor_ack_q_left", ack_q.size(), 0);
        check("oor_run_len", done_cyc - start_cyc, 46);

        // Reset during the third SEND with ready high, start asserted alongside.
        do_reset();
        load_acks();
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!(pkt_valid && pkt_log.size() == 2) && n < 30) begin step(); n++; end
        check("mid_in_send", pkt_valid, 1);
        rst = 1'b1; start = 1'b1;
        step();
        check("mid_busy", busy, 0);
        check("mid_pkt_valid", pkt_valid, 0);
        check("mid_pkt_data", pkt_data, 0);
        check("mid_no_handshake", pkt_log.size(), 2);
        rst = 1'b0; start = 1'b0;
        step();
        check("mid_rst_over_start", busy, 0);
        clear_logs();
        ack_q.delete();
        load_acks();
        run_to_done(-1);
        check_packets("mid_rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
